// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Count direction encoding and address-width helper.
package reg_file_pkg;

    typedef enum logic {
        CNT_DEC = 1'b0,
        CNT_INC = 1'b1
    } cnt_dir_e;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_file_nport_cell.sv
// One register of the file: clear > load > count.
// Flags a wrap when the count steps across the all-ones/zero seam.
module reg_cell
    import reg_file_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             cnt,
    input  cnt_dir_e         dir,
    output logic [WIDTH-1:0] q,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = RESET_VAL;
        end else if (ld) begin
            q_d = ld_data;
        end else if (cnt) begin
            q_d = (dir == CNT_INC) ? q_q + ONE : q_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign wrapped = cnt & ~ld & ~clr &
                     ((dir == CNT_INC) ? (&q_q) : ~(|q_q));

endmodule

// File: rtl/reg_file_nport.sv
// Register file: one write port, two read ports, one inc/dec port.
// Registered Z/N flags of the last update and a one-cycle wrap pulse.
module reg_file_nport
    import reg_file_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               NUM_REGS = 4,
    parameter int               SP_IDX   = 3,
    parameter logic [WIDTH-1:0] SP_RESET = 8'hFF,
    parameter bit               BYPASS   = 1'b1,
    localparam int              AW       = addr_w(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             cnt_en,
    input  logic [AW-1:0]    cnt_addr,
    input  cnt_dir_e         cnt_dir,
    input  logic [AW-1:0]    rd_a_addr,
    output logic [WIDTH-1:0] rd_a_data,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_b_data,
    output logic             z_flag,
    output logic             n_flag,
    output logic             wrap
);

    localparam int               NTAB = 1 << AW;
    localparam logic [AW:0]      NR   = (AW+1)'(NUM_REGS);
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             wr_ok;
    logic             cnt_ok;
    logic [WIDTH-1:0] tab    [NTAB];
    logic [NTAB-1:0]  wrap_v;
    logic [WIDTH-1:0] cnt_cur;
    logic [WIDTH-1:0] cnt_nxt;

    logic z_q, z_d;
    logic n_q, n_d;
    logic wrap_q, wrap_d;

    // A same-index write swallows the count entirely.
    assign wr_ok  = wr_en & ({1'b0, wr_addr} < NR);
    assign cnt_ok = cnt_en & ({1'b0, cnt_addr} < NR) &
                    ~(wr_ok & (wr_addr == cnt_addr));

    for (genvar g = 0; g < NTAB; g++) begin : g_reg
        if (g < NUM_REGS) begin : g_cell
            reg_cell #(
                .WIDTH    (WIDTH),
                .RESET_VAL((g == SP_IDX) ? SP_RESET : '0)
            ) u_cell (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (clr),
                .ld     (wr_ok & (wr_addr == AW'(g))),
                .ld_data(wr_data),
                .cnt    (cnt_ok & (cnt_addr == AW'(g))),
                .dir    (cnt_dir),
                .q      (tab[g]),
                .wrapped(wrap_v[g])
            );
        end else begin : g_pad
            assign tab[g]    = '0;
            assign wrap_v[g] = 1'b0;
        end
    end

    assign cnt_cur = tab[cnt_addr];
    assign cnt_nxt = (cnt_dir == CNT_INC) ? cnt_cur + ONE : cnt_cur - ONE;

    always_comb begin
        rd_a_data = tab[rd_a_addr];
        rd_b_data = tab[rd_b_addr];
        if (BYPASS && wr_ok && !clr) begin
            if (rd_a_addr == wr_addr) rd_a_data = wr_data;
            if (rd_b_addr == wr_addr) rd_b_data = wr_data;
        end
    end

    always_comb begin
        z_d    = z_q;
        n_d    = n_q;
        wrap_d = 1'b0;
        if (clr) begin
            z_d = 1'b0;
            n_d = 1'b0;
        end else begin
            wrap_d = |wrap_v;
            if (wr_ok) begin
                z_d = ~(|wr_data);
                n_d = wr_data[WIDTH-1];
            end else if (cnt_ok) begin
                z_d = ~(|cnt_nxt);
                n_d = cnt_nxt[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            z_q    <= z_d;
            n_q    <= n_d;
            wrap_q <= wrap_d;
        end
    end

    assign z_flag = z_q;
    assign n_flag = n_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_reg_file_nport.sv
// Directed bench for reg_file_nport (4-register default and a 3-register copy).
module tb_reg_file_nport;
    import reg_file_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       cnt_en;
    logic [1:0] cnt_addr;
    cnt_dir_e   cnt_dir;
    logic [1:0] rd_a_addr;
    logic [1:0] rd_b_addr;

    logic [7:0] rd_a, rd_b, rd_a3, rd_b3;
    logic       z, n, wr, z3, n3, wr3;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_file_nport u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cnt_en   (cnt_en),
        .cnt_addr (cnt_addr),
        .cnt_dir  (cnt_dir),
        .rd_a_addr(rd_a_addr),
        .rd_a_data(rd_a),
        .rd_b_addr(rd_b_addr),
        .rd_b_data(rd_b),
        .z_flag   (z),
        .n_flag   (n),
        .wrap     (wr)
    );

    reg_file_nport #(.NUM_REGS(3), .SP_IDX(2)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cnt_en   (cnt_en),
        .cnt_addr (cnt_addr),
        .cnt_dir  (cnt_dir),
        .rd_a_addr(rd_a_addr),
        .rd_a_data(rd_a3),
        .rd_b_addr(rd_b_addr),
        .rd_b_data(rd_b3),
        .z_flag   (z3),
        .n_flag   (n3),
        .wrap     (wr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        cnt_en = 1'b0;
        clr    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cnt_en = 1'b0; cnt_addr = '0; cnt_dir = CNT_INC;
        rd_a_addr = 2'd0; rd_b_addr = 2'd3;

        // async reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd0", rd_a, 8'h00);
        chk("rst_rd3", rd_b, 8'hFF);
        chk("rst_z", z, 1'b0);
        chk("rst_n", n, 1'b0);
        chk("rst_wrap", wr, 1'b0);
        rd_a_addr = 2'd1; rd_b_addr = 2'd2;
        #1;
        chk("rst_rd1", rd_a, 8'h00);
        chk("rst_rd2", rd_b, 8'h00);
        chk("rst3_rd2", rd_b3, 8'hFF);
        #1 rst_n = 1'b1;
        tick();

        // write 80 to idx1, bypass in the write cycle
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h80;
        rd_a_addr = 2'd1; rd_b_addr = 2'd1;
        #1;
        chk("wr_bypass_a", rd_a, 8'h80);
        chk("wr_bypass_b", rd_b, 8'h80);
        tick();
        idle();
        #1;
        chk("wr_rd1", rd_a, 8'h80);
        chk("wr_n", n, 1'b1);
        chk("wr_z", z, 1'b0);
        chk("wr_wrap", wr, 1'b0);

        // inc idx3 FF -> 00
        cnt_en = 1'b1; cnt_addr = 2'd3; cnt_dir = CNT_INC;
        rd_a_addr = 2'd3;
        #1;
        chk("cnt_nobypass", rd_a, 8'hFF);
        tick();
        idle();
        #1;
        chk("inc_rd3", rd_a, 8'h00);
        chk("inc_wrap", wr, 1'b1);
        chk("inc_z", z, 1'b1);
        chk("inc_n", n, 1'b0);
        tick();
        chk("inc_wrap_gone", wr, 1'b0);
        chk("inc_z_hold", z, 1'b1);

        // dec idx3 00 -> FF
        cnt_en = 1'b1; cnt_addr = 2'd3; cnt_dir = CNT_DEC;
        tick();
        idle();
        #1;
        chk("dec_rd3", rd_a, 8'hFF);
        chk("dec_wrap", wr, 1'b1);
        chk("dec_n", n, 1'b1);
        chk("dec_z", z, 1'b0);
        tick();
        chk("dec_wrap_gone", wr, 1'b0);

        // write and count same index: write wins
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h05;
        cnt_en = 1'b1; cnt_addr = 2'd2; cnt_dir = CNT_INC;
        tick();
        idle();
        rd_a_addr = 2'd2;
        #1;
        chk("same_rd2", rd_a, 8'h05);
        chk("same_wrap", wr, 1'b0);
        chk("same_z", z, 1'b0);
        chk("same_n", n, 1'b0);

        // write idx2, count idx0 down across zero
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h05;
        cnt_en = 1'b1; cnt_addr = 2'd0; cnt_dir = CNT_DEC;
        tick();
        idle();
        rd_a_addr = 2'd0; rd_b_addr = 2'd2;
        #1;
        chk("diff_rd0", rd_a, 8'hFF);
        chk("diff_rd2", rd_b, 8'h05);
        chk("diff_wrap", wr, 1'b1);
        chk("diff_z", z, 1'b0);
        chk("diff_n", n, 1'b0);

        // plain inc, no wrap; flags from new value
        cnt_en = 1'b1; cnt_addr = 2'd2; cnt_dir = CNT_INC;
        tick();
        idle();
        #1;
        chk("inc6_rd2", rd_b, 8'h06);
        chk("inc6_wrap", wr, 1'b0);

        // clr beats write and count
        clr = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h33;
        cnt_en = 1'b1; cnt_addr = 2'd0; cnt_dir = CNT_INC;
        rd_a_addr = 2'd1;
        #1;
        chk("clr_nobypass", rd_a, 8'h80);
        tick();
        idle();
        rd_a_addr = 2'd0; rd_b_addr = 2'd1;
        #1;
        chk("clr_rd0", rd_a, 8'h00);
        chk("clr_rd1", rd_b, 8'h00);
        rd_a_addr = 2'd2; rd_b_addr = 2'd3;
        #1;
        chk("clr_rd2", rd_a, 8'h00);
        chk("clr_rd3", rd_b, 8'hFF);
        chk("clr_z", z, 1'b0);
        chk("clr_n", n, 1'b0);
        chk("clr_wrap", wr, 1'b0);

        // write zero -> z set, then holds while idle
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h00;
        tick();
        idle();
        chk("wr0_z", z, 1'b1);
        tick();
        chk("idle_z_hold", z, 1'b1);
        chk("idle_n_hold", n, 1'b0);

        // 3-register copy: idx3 is out of range
        chk("r3_pre_z", z3, 1'b1);
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h80;
        rd_a_addr = 2'd3; rd_b_addr = 2'd2;
        #1;
        chk("r3_nobypass", rd_a3, 8'h00);
        tick();
        idle();
        #1;
        chk("r3_rd3", rd_a3, 8'h00);
        chk("r3_rd2", rd_b3, 8'hFF);
        chk("r3_z_hold", z3, 1'b1);
        chk("r3_n_hold", n3, 1'b0);
        chk("r4_rd3", rd_a, 8'h80);
        cnt_en = 1'b1; cnt_addr = 2'd3; cnt_dir = CNT_DEC;
        tick();
        idle();
        #1;
        chk("r3_cnt_wrap", wr3, 1'b0);
        chk("r3_cnt_z", z3, 1'b1);
        rd_a_addr = 2'd0; rd_b_addr = 2'd1;
        #1;
        chk("r3_rd0", rd_a3, 8'h00);
        chk("r3_rd1", rd_b3, 8'h00);

        // reset during a count
        cnt_en = 1'b1; cnt_addr = 2'd3; cnt_dir = CNT_DEC;
        rd_a_addr = 2'd3;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_rd3", rd_a, 8'hFF);
        chk("rst_mid_z", z, 1'b0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_hold", rd_a, 8'hFF);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
